if_id_reg: RTL and testbench

- F/D pipeline register of the five-stage MIPS core.
- Captures the instruction-fetch unit's PC and instruction each cycle and presents them to the decode stage.
- Supports stall (hold), flush (bubble insert) and a delay-slot flag.
- Checks the fetch address (AdEL) and keeps saturating stall/bubble counters for performance debug.

---
 rtl/if_id_reg_pkg.sv | 35 +++
 rtl/if_id_reg_sat_counter.sv | 26 ++
 rtl/if_id_reg.sv | 88 ++++++++
 tb/tb_if_id_reg.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_reg_pkg.sv
// Shared pipeline definitions: exception codes, memory-map defaults and the
// fetch-address legality check used by the F/D register.
package if_id_reg_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
    localparam int unsigned DEF_IM_WORDS = 4096;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } dstate_t;

    // 33-bit bounds so a window ending at the top of the address space cannot wrap.
    function automatic logic fetch_fault(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input int unsigned words);
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] pc_x;
        lo   = {1'b0, base};
        hi   = lo + (33'(words) << 2);
        pc_x = {1'b0, pc};
        return (pc[1:0] != 2'b00) || (pc_x < lo) || (pc_x >= hi);
    endfunction

endpackage

// File: rtl/if_id_reg_sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/if_id_reg.sv
// F/D pipeline register: captures fetch PC/instruction, supports stall, flush
// and delay-slot tracking, flags AdEL on fetch and counts stall/bubble cycles.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
    parameter int unsigned IM_WORDS = DEF_IM_WORDS,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      f_pc,
    input  logic [31:0]      f_instr,
    input  logic             f_bd,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_pc8,
    output logic [31:0]      d_instr,
    output logic             d_valid,
    output logic             d_bd,
    output logic [4:0]       d_exccode,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    dstate_t     r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_bd;
    logic [4:0]  r_exc;

    logic        w_fault;
    logic        w_stall_ev;
    logic        w_bubble_ev;

    assign w_fault     = fetch_fault(f_pc, IM_BASE, IM_WORDS);
    assign w_stall_ev  = stall && !flush;
    assign w_bubble_ev = flush;

    // Priority flush > stall > load; d_valid is the EMPTY/FULL state bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
            r_pc    <= RESET_PC;
            r_instr <= NOP;
            r_bd    <= 1'b0;
            r_exc   <= EXC_NONE;
        end else if (flush) begin
            r_state <= ST_EMPTY;
            r_pc    <= f_pc;
            r_instr <= NOP;
            r_bd    <= 1'b0;
            r_exc   <= EXC_NONE;
        end else if (!stall) begin
            r_state <= ST_FULL;
            r_pc    <= f_pc;
            r_bd    <= f_bd;
            r_instr <= w_fault ? NOP : f_instr;
            r_exc   <= w_fault ? EXC_ADEL : EXC_NONE;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (w_stall_ev),
        .clr   (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (w_bubble_ev),
        .clr   (1'b0),
        .cnt   (bubble_cnt)
    );

    assign d_pc      = r_pc;
    assign d_pc8     = r_pc + 32'd8;
    assign d_instr   = r_instr;
    assign d_valid   = (r_state == ST_FULL);
    assign d_bd      = r_bd;
    assign d_exccode = r_exc;

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: rule-level reference model checked every cycle plus
// hand-computed literal checkpoints; narrow counters make saturation reachable.
module tb_if_id_reg;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          flush;
    logic [31:0]   f_pc;
    logic [31:0]   f_instr;
    logic          f_bd;
    logic [31:0]   d_pc;
    logic [31:0]   d_pc8;
    logic [31:0]   d_instr;
    logic          d_valid;
    logic          d_bd;
    logic [4:0]    d_exccode;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_pc, m_instr;
    logic        m_valid, m_bd;
    logic [4:0]  m_exc;
    int          m_scnt, m_bcnt;

    if_id_reg #(
        .RESET_PC (32'h0000_3000),
        .IM_BASE  (32'h0000_3000),
        .IM_WORDS (4096),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .f_pc       (f_pc),
        .f_instr    (f_instr),
        .f_bd       (f_bd),
        .d_pc       (d_pc),
        .d_pc8      (d_pc8),
        .d_instr    (d_instr),
        .d_valid    (d_valid),
        .d_bd       (d_bd),
        .d_exccode  (d_exccode),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: legal fetch window is 0x3000 .. 0x3000+4*4096-1.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = 32'h3000; m_instr = 0; m_valid = 0; m_bd = 0; m_exc = 0;
            m_scnt = 0; m_bcnt = 0;
        end else if (flush) begin
            m_pc = f_pc; m_instr = 0; m_valid = 0; m_bd = 0; m_exc = 0;
            if (m_bcnt < CMAX) m_bcnt = m_bcnt + 1;
        end else if (stall) begin
            if (m_scnt < CMAX) m_scnt = m_scnt + 1;
        end else begin
            longint pcl;
            bit bad;
            pcl = longint'(f_pc);
            bad = (pcl % 4 != 0) || (pcl < 64'h3000) || (pcl >= 64'h3000 + 4 * 4096);
            m_pc = f_pc; m_bd = f_bd; m_valid = 1;
            m_exc = bad ? 5'd4 : 5'd0;
            m_instr = bad ? 32'h0 : f_instr;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc",      d_pc,              m_pc);
            chk("pc8",     d_pc8,             m_pc + 32'd8);
            chk("instr",   d_instr,           m_instr);
            chk("valid",   32'(d_valid),      32'(m_valid));
            chk("bd",      32'(d_bd),         32'(m_bd));
            chk("exc",     32'(d_exccode),    32'(m_exc));
            chk("scnt",    32'(stall_cnt),    32'(m_scnt));
            chk("bcnt",    32'(bubble_cnt),   32'(m_bcnt));
        end
    end

    task automatic step(input logic s, input logic f, input logic [31:0] pc,
                        input logic [31:0] ins, input logic b);
        stall = s; flush = f; f_pc = pc; f_instr = ins; f_bd = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 0; flush = 0; f_pc = 32'h3000; f_instr = 32'h3C010001; f_bd = 0;
        #1 reset = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("rst_pc",    d_pc,            32'h3000);
        chk("rst_pc8",   d_pc8,           32'h3008);
        chk("rst_instr", d_instr,         32'h0);
        chk("rst_valid", 32'(d_valid),    32'h0);
        chk("rst_scnt",  32'(stall_cnt),  32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        step(0, 0, 32'h3000, 32'h3C010001, 0);
        chk("first_pc",    d_pc,         32'h3000);
        chk("first_instr", d_instr,      32'h3C010001);
        chk("first_valid", 32'(d_valid), 32'h1);
        chk("first_pc8",   d_pc8,        32'h3008);

        for (int i = 0; i < 3; i++) step(1, 0, 32'h3004 + 32'(4 * i), 32'hA0 + 32'(i), 0);
        chk("stall_pc",    d_pc,            32'h3000);
        chk("stall_instr", d_instr,         32'h3C010001);
        chk("stall_scnt",  32'(stall_cnt),  32'd3);
        chk("stall_bcnt",  32'(bubble_cnt), 32'd0);

        step(1, 1, 32'h3010, 32'hDEADBEEF, 1);
        chk("sf_valid", 32'(d_valid),    32'h0);
        chk("sf_instr", d_instr,         32'h0);
        chk("sf_pc",    d_pc,            32'h3010);
        chk("sf_bcnt",  32'(bubble_cnt), 32'd1);
        chk("sf_scnt",  32'(stall_cnt),  32'd3);

        step(0, 0, 32'h3002, 32'h12345678, 0);
        chk("mis_exc",   32'(d_exccode), 32'd4);
        chk("mis_instr", d_instr,        32'h0);
        chk("mis_valid", 32'(d_valid),   32'h1);
        step(0, 0, 32'h6FFC, 32'hAAAA5555, 0);
        chk("top_exc",   32'(d_exccode), 32'd0);
        chk("top_instr", d_instr,        32'hAAAA5555);
        step(0, 0, 32'h7000, 32'h5555AAAA, 0);
        chk("end_exc",   32'(d_exccode), 32'd4);
        step(0, 0, 32'h2FFC, 32'h01010101, 0);
        chk("low_exc",   32'(d_exccode), 32'd4);
        step(0, 0, 32'hFFFF_FFFC, 32'h02020202, 0);
        chk("wrap_exc",  32'(d_exccode), 32'd4);

        step(0, 0, 32'h3020, 32'h11111111, 1);
        chk("bd_load", 32'(d_bd), 32'h1);
        step(0, 1, 32'h3024, 32'h44444444, 1);
        chk("bd_flush", 32'(d_bd), 32'h0);
        chk("bd_bcnt",  32'(bubble_cnt), 32'd2);

        step(0, 0, 32'h3028, 32'h22222222, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 32'h4000 + 32'(4 * i), 32'(i), 1);
        chk("sat_scnt",  32'(stall_cnt), 32'd15);
        chk("hold_pc",   d_pc,           32'h3028);
        chk("hold_inst", d_instr,        32'h22222222);

        for (int i = 0; i < 16; i++) step(i[0], 1, 32'h5000 + 32'(4 * i), 32'hFF, 0);
        chk("sat_bcnt",  32'(bubble_cnt), 32'd15);
        chk("sat_scnt2", 32'(stall_cnt),  32'd15);

        step(0, 0, 32'h3030, 32'h33330000, 1);
        step(1, 0, 32'h3034, 32'h33330004, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_pc",    d_pc,            32'h3000);
        chk("arst_pc8",   d_pc8,           32'h3008);
        chk("arst_valid", 32'(d_valid),    32'h0);
        chk("arst_bd",    32'(d_bd),       32'h0);
        chk("arst_scnt",  32'(stall_cnt),  32'h0);
        chk("arst_bcnt",  32'(bubble_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        step(0, 0, 32'h3040, 32'h33333333, 0);
        chk("rel_pc",    d_pc,         32'h3040);
        chk("rel_valid", 32'(d_valid), 32'h1);
        chk("rel_scnt",  32'(stall_cnt), 32'h0);
        step(0, 0, 32'h3044, 32'h44445555, 0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
